// File: rtl/mode_ff_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mode_ff_bank_if
//  Purpose  : Signal bundle for the mode-selectable flip-flop bank.
//             The master drives the controls and operands; the slave (the
//             bank) drives the stored state and the error reporting.
//  Signals  : mode[1:0]      00=SR 01=JK 10=D 11=T
//             e/a/b[WIDTH]   per-bit enable, first and second operand
//             clr_err        synchronous clear of err_sticky / err_cnt
//             q/qb[WIDTH]    stored state and its complement
//             err[WIDTH]     per-bit illegal-SR flag from the last edge
//             err_sticky     any illegal event since the last clear
//             err_cnt[CNT_W] saturating count of illegal edges
//  Revision : 1.0 - initial release
// ============================================================================
interface mode_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] err;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output mode, e, a, b, clr_err,
    input  q, qb, err, err_sticky, err_cnt
  );

  modport slave (
    input  mode, e, a, b, clr_err,
    output q, qb, err, err_sticky, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mode_ff_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mode_ff_bank
//  Purpose  : WIDTH independent edge-triggered storage bits. A single global
//             mode selects SR, JK, D or T next-state behaviour for all bits.
//             Illegal SR events (S=R=1) hold the bit and are reported via a
//             per-bit flag, a sticky flag and a saturating event counter.
//  Ports    : clk      rising-edge clock
//             rst_n    asynchronous active-low reset
//             bus      mode_ff_bank_if.slave
//                        in : mode, e, a, b, clr_err
//                        out: q, qb, err, err_sticky, err_cnt
//  Revision : 1.0 - initial release
// ============================================================================
module mode_ff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mode_ff_bank_if.slave  bus
);

  localparam logic [1:0]       MODE_SR = 2'b00;
  localparam logic [1:0]       MODE_JK = 2'b01;
  localparam logic [1:0]       MODE_D  = 2'b10;
  localparam logic [1:0]       MODE_T  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] err;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] illegal;
  logic             illegal_any;

  // Per-bit next-state selection. A disabled bit always holds.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic nq;

    always_comb begin
      nq = q[i];
      if (bus.e[i]) begin
        case (bus.mode)
          MODE_SR: begin
            // S=R=1 falls through to hold so the bit never goes unknown.
            if (bus.a[i] && !bus.b[i])      nq = 1'b1;
            else if (!bus.a[i] && bus.b[i]) nq = 1'b0;
            else                            nq = q[i];
          end
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   nq = 1'b0;
              2'b10:   nq = 1'b1;
              2'b11:   nq = ~q[i];
              default: nq = q[i];
            endcase
          end
          MODE_D:  nq = bus.a[i];
          MODE_T:  nq = bus.a[i] ? ~q[i] : q[i];
          default: nq = q[i];
        endcase
      end
    end

    assign next_q[i]  = nq;
    assign illegal[i] = (bus.mode == MODE_SR) & bus.e[i] & bus.a[i] & bus.b[i];
  end

  assign illegal_any = |illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RST_VAL;
      err        <= '0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      q   <= next_q;
      err <= illegal;
      // Clear has priority: an illegal event on a clearing edge is dropped.
      if (bus.clr_err) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end else if (illegal_any) begin
        err_sticky <= 1'b1;
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.q          = q;
  assign bus.qb         = ~q;
  assign bus.err        = err;
  assign bus.err_sticky = err_sticky;
  assign bus.err_cnt    = err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mode_ff_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mode_ff_bank
//  Purpose  : Directed-vector bench for mode_ff_bank. Two instances share the
//             same stimulus: one with default parameters and one with a
//             2-bit error counter to exercise saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mode_ff_bank;

  logic clk;
  logic rst_n;

  mode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  mode_ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  mode_ff_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'h00)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  mode_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] err;
    logic       st;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] e, input logic [7:0] a,
                       input logic [7:0] b, input logic clr);
    bus8.mode = m; bus8.e = e; bus8.a = a; bus8.b = b; bus8.clr_err = clr;
    bus2.mode = m; bus2.e = e; bus2.a = a; bus2.b = b; bus2.clr_err = clr;
  endtask

  // Apply one vector before the next rising edge and queue its expected result.
  task automatic issue(input logic [1:0] m, input logic [7:0] e, input logic [7:0] a,
                       input logic [7:0] b, input logic clr,
                       input logic [7:0] q, input logic [7:0] err, input logic st,
                       input logic [7:0] c8, input logic [1:0] c2);
    exp_t t;
    @(negedge clk);
    drive(m, e, a, b, clr);
    t.q = q; t.err = err; t.st = st; t.c8 = c8; t.c2 = c2;
    sb.push_back(t);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_q"},      {24'h0, bus8.q},          32'h00);
    chk({tag, "_qb"},     {24'h0, bus8.qb},         32'hFF);
    chk({tag, "_err"},    {24'h0, bus8.err},        32'h00);
    chk({tag, "_sticky"}, {31'h0, bus8.err_sticky}, 32'h0);
    chk({tag, "_cnt8"},   {24'h0, bus8.err_cnt},    32'h0);
    chk({tag, "_q2"},     {24'h0, bus2.q},          32'h00);
    chk({tag, "_cnt2"},   {30'h0, bus2.err_cnt},    32'h0);
  endtask

  // Monitor: after each rising edge, compare against the oldest queued result.
  always @(posedge clk) begin
    #2;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("q",       {24'h0, bus8.q},          {24'h0, x.q});
      chk("qb",      {24'h0, bus8.qb},         {24'h0, ~x.q});
      chk("err",     {24'h0, bus8.err},        {24'h0, x.err});
      chk("sticky",  {31'h0, bus8.err_sticky}, {31'h0, x.st});
      chk("cnt8",    {24'h0, bus8.err_cnt},    {24'h0, x.c8});
      chk("q2",      {24'h0, bus2.q},          {24'h0, x.q});
      chk("err2",    {24'h0, bus2.err},        {24'h0, x.err});
      chk("sticky2", {31'h0, bus2.err_sticky}, {31'h0, x.st});
      chk("cnt2",    {30'h0, bus2.err_cnt},    {30'h0, x.c2});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #2 reset_chk("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //      mode   e      a      b      clr   q      err    st    c8     c2
    issue(2'b00, 8'hFF, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'h00, 1'b0, 8'd0, 2'd0); // SR set/reset
    issue(2'b10, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0, 2'd0); // D clear
    issue(2'b10, 8'h0F, 8'hAA, 8'hFF, 1'b0, 8'h0A, 8'h00, 1'b0, 8'd0, 2'd0); // D masked
    issue(2'b10, 8'h00, 8'h55, 8'h00, 1'b0, 8'h0A, 8'h00, 1'b0, 8'd0, 2'd0); // all disabled
    issue(2'b10, 8'h00, 8'h55, 8'h00, 1'b0, 8'h0A, 8'h00, 1'b0, 8'd0, 2'd0);
    issue(2'b10, 8'h00, 8'h55, 8'h00, 1'b0, 8'h0A, 8'h00, 1'b0, 8'd0, 2'd0);
    issue(2'b10, 8'hFF, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b0, 8'd0, 2'd0);
    issue(2'b00, 8'hFF, 8'h81, 8'h81, 1'b0, 8'h0F, 8'h81, 1'b1, 8'd1, 2'd1); // SR illegal holds
    issue(2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b1, 8'd1, 2'd1);
    issue(2'b10, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1, 2'd1);
    issue(2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b1, 8'd1, 2'd1); // JK toggle
    issue(2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1, 2'd1);
    issue(2'b11, 8'hFF, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'h00, 1'b1, 8'd1, 2'd1); // T
    issue(2'b11, 8'h0F, 8'hFF, 8'h00, 1'b0, 8'h33, 8'h00, 1'b1, 8'd1, 2'd1); // T masked
    issue(2'b01, 8'hFF, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'h00, 1'b1, 8'd1, 2'd1); // JK set/reset
    issue(2'b01, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b1, 8'd1, 2'd1); // JK hold
    issue(2'b00, 8'h01, 8'hFF, 8'hFF, 1'b0, 8'hF0, 8'h01, 1'b1, 8'd2, 2'd2); // illegal only where enabled
    issue(2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 8'hF0, 8'h00, 1'b0, 8'd0, 2'd0); // clear
    issue(2'b00, 8'hFF, 8'h10, 8'h10, 1'b0, 8'hF0, 8'h10, 1'b1, 8'd1, 2'd1); // saturation run
    issue(2'b00, 8'hFF, 8'h10, 8'h10, 1'b0, 8'hF0, 8'h10, 1'b1, 8'd2, 2'd2);
    issue(2'b00, 8'hFF, 8'h10, 8'h10, 1'b0, 8'hF0, 8'h10, 1'b1, 8'd3, 2'd3);
    issue(2'b00, 8'hFF, 8'h10, 8'h10, 1'b0, 8'hF0, 8'h10, 1'b1, 8'd4, 2'd3);
    issue(2'b00, 8'hFF, 8'h10, 8'h10, 1'b0, 8'hF0, 8'h10, 1'b1, 8'd5, 2'd3);
    issue(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hF0, 8'hFF, 1'b0, 8'd0, 2'd0); // clear beats illegal
    issue(2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h0F, 8'h00, 1'b0, 8'd0, 2'd0); // JK 11 never errors
    issue(2'b00, 8'hFF, 8'h80, 8'h01, 1'b0, 8'h8E, 8'h00, 1'b0, 8'd0, 2'd0);
    issue(2'b00, 8'hFF, 8'h02, 8'h02, 1'b0, 8'h8E, 8'h02, 1'b1, 8'd1, 2'd1);

    // Asynchronous reset between edges, after the last result is checked.
    @(posedge clk);
    #4;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1 reset_chk("rst_async");
    @(posedge clk);
    #1 reset_chk("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b10, 8'hFF, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0, 8'd0, 2'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
